// File: rtl/prim_scheduler.sv
// Breaks line/rectangle/triangle draw commands into clamped line segments
// and hands them one at a time to the line generator.
module prim_scheduler #(
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [18:0] cmd_v0,
    input  logic [18:0] cmd_v1,
    input  logic [18:0] cmd_v2,
    input  logic        fb_full,
    output logic [37:0] positions,
    output logic        primSelect,
    input  logic        lineDone,
    output logic        stop,
    output logic        busy,
    output logic        prim_done,
    output logic        cmd_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_e;

    localparam logic [9:0] X_LIM = 10'(X_MAX);
    localparam logic [8:0] Y_LIM = 9'(Y_MAX);

    localparam logic [1:0] T_LINE = 2'b00;
    localparam logic [1:0] T_RECT = 2'b01;
    localparam logic [1:0] T_TRI  = 2'b10;
    localparam logic [1:0] T_RSVD = 2'b11;

    function automatic logic [18:0] clamp_vtx(input logic [18:0] v);
        logic [9:0] x;
        logic [8:0] y;
        x = v[18:9];
        y = v[8:0];
        if (x > X_LIM) x = X_LIM;
        if (y > Y_LIM) y = Y_LIM;
        return {x, y};
    endfunction

    // Rectangle edges walk the corners (x0,y0)->(x1,y0)->(x1,y1)->(x0,y1) and close.
    function automatic logic [37:0] seg_pos(input logic [1:0]  t,
                                            input logic [1:0]  idx,
                                            input logic [18:0] a,
                                            input logic [18:0] b,
                                            input logic [18:0] c);
        logic [9:0]  ax, bx;
        logic [8:0]  ay, by;
        logic [37:0] r;
        ax = a[18:9];
        ay = a[8:0];
        bx = b[18:9];
        by = b[8:0];
        r  = {a, b};
        case (t)
            T_RECT: begin
                case (idx)
                    2'd0:    r = {ax, ay, bx, ay};
                    2'd1:    r = {bx, ay, bx, by};
                    2'd2:    r = {bx, by, ax, by};
                    default: r = {ax, by, ax, ay};
                endcase
            end
            T_TRI: begin
                case (idx)
                    2'd0:    r = {a, b};
                    2'd1:    r = {b, c};
                    default: r = {c, a};
                endcase
            end
            default: r = {a, b};
        endcase
        return r;
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] t);
        logic [1:0] r;
        case (t)
            T_RECT:  r = 2'd3;
            T_TRI:   r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  type_q, type_d;
    logic [18:0] v0_q, v0_d;
    logic [18:0] v1_q, v1_d;
    logic [18:0] v2_q, v2_d;
    logic [37:0] pos_q, pos_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [18:0] c0, c1, c2;
    logic [1:0]  idx_nxt;
    logic        accept;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        type_d     = type_q;
        v0_d       = v0_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        pos_d      = pos_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        primSelect = 1'b0;
        busy       = (state_q != S_IDLE);
        cmd_ready  = (state_q == S_IDLE) && !rst;
        accept     = cmd_valid && cmd_ready;
        c0         = clamp_vtx(cmd_v0);
        c1         = clamp_vtx(cmd_v1);
        c2         = clamp_vtx(cmd_v2);
        idx_nxt    = idx_q + 2'd1;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_type == T_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        type_d  = cmd_type;
                        v0_d    = c0;
                        v1_d    = c1;
                        v2_d    = c2;
                        idx_d   = 2'd0;
                        pos_d   = seg_pos(cmd_type, 2'd0, c0, c1, c2);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!fb_full) begin
                    primSelect = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lineDone) begin
                    if (idx_q == last_idx(type_q)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_nxt;
                        pos_d   = seg_pos(type_q, idx_nxt, v0_q, v1_q, v2_q);
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            type_q  <= T_LINE;
            v0_q    <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            pos_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            type_q  <= type_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            pos_q   <= pos_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign positions = pos_q;
    assign prim_done = done_q;
    assign cmd_err   = err_q;
    assign stop      = fb_full;

endmodule

// File: tb/tb_prim_scheduler.sv
// Self-checking bench for prim_scheduler: directed cases plus random commands
// compared against a polygon-edge reference model and a generator model.
module tb_prim_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [18:0] cmd_v0, cmd_v1, cmd_v2;
    logic        fb_full;
    logic [37:0] positions;
    logic        primSelect;
    logic        lineDone;
    logic        stop;
    logic        busy;
    logic        prim_done;
    logic        cmd_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [37:0] exp_q[$];

    always #5 clk = ~clk;

    prim_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_type   (cmd_type),
        .cmd_v0     (cmd_v0),
        .cmd_v1     (cmd_v1),
        .cmd_v2     (cmd_v2),
        .fb_full    (fb_full),
        .positions  (positions),
        .primSelect (primSelect),
        .lineDone   (lineDone),
        .stop       (stop),
        .busy       (busy),
        .prim_done  (prim_done),
        .cmd_err    (cmd_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [18:0] pt(input int x, input int y);
        return {10'(x), 9'(y)};
    endfunction

    function automatic logic [18:0] clampv(input logic [18:0] v);
        int x, y;
        x = int'(v[18:9]);
        y = int'(v[8:0]);
        if (x > 639) x = 639;
        if (y > 479) y = 479;
        return pt(x, y);
    endfunction

    // Expected segment list: a line is one open edge, rectangles and triangles are closed polygons.
    task automatic build(input logic [1:0] t, input logic [18:0] a, input logic [18:0] b,
                         input logic [18:0] c);
        logic [18:0] p[4];
        logic [18:0] ca, cb, cc;
        ca = clampv(a);
        cb = clampv(b);
        cc = clampv(c);
        exp_q.delete();
        if (t == 2'b00) begin
            exp_q.push_back({ca, cb});
        end else if (t == 2'b01) begin
            p[0] = ca;
            p[1] = {cb[18:9], ca[8:0]};
            p[2] = cb;
            p[3] = {ca[18:9], cb[8:0]};
            for (int i = 0; i < 4; i++) exp_q.push_back({p[i], p[(i + 1) % 4]});
        end else if (t == 2'b10) begin
            p[0] = ca;
            p[1] = cb;
            p[2] = cc;
            p[3] = '0;
            for (int i = 0; i < 3; i++) exp_q.push_back({p[i], p[(i + 1) % 3]});
        end
    endtask

    task automatic run_cmd(input logic [1:0] t, input logic [18:0] a, input logic [18:0] b,
                           input logic [18:0] c, input int lat, input int fb_cycles,
                           input bit noise, input int abort_seg);
        int seg = 0;
        int cnt = 0;
        bit pending = 1'b1;
        bit waiting = 1'b0;
        bit done_due = 1'b0;
        bit finished = 1'b0;
        bit aborted = 1'b0;
        bit ld;
        build(t, a, b, c);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_v0    = a;
        cmd_v1    = b;
        cmd_v2    = c;
        fb_full   = (fb_cycles > 0);
        lineDone  = 1'b0;
        @(negedge clk);
        check("ready_before_accept", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_type  = 2'($urandom);
        cmd_v0    = 19'($urandom);
        cmd_v1    = 19'($urandom);
        cmd_v2    = 19'($urandom);
        if (t == 2'b11) begin
            fb_full = 1'b0;
            @(negedge clk);
            check("err_pulse", cmd_err, 1);
            check("err_no_primsel", primSelect, 0);
            check("err_stays_idle", cmd_ready, 1);
            check("err_not_busy", busy, 0);
            @(posedge clk); #1;
            @(negedge clk);
            check("err_one_cycle", cmd_err, 0);
            check("err_no_primsel2", primSelect, 0);
            return;
        end
        for (int k = 1; k <= 400 && !finished && !aborted; k++) begin
            if (abort_seg >= 0 && waiting && seg == abort_seg) begin
                aborted = 1'b1;
            end else begin
                fb_full = (k <= fb_cycles) || (noise && $urandom_range(0, 3) == 0);
                if (waiting && cnt > 0) cnt--;
                ld = waiting && (cnt == 0);
                lineDone = ld;
                @(negedge clk);
                check("stop", stop, fb_full);
                check("prim_done", prim_done, done_due);
                check("cmd_err_quiet", cmd_err, 0);
                if (done_due) begin
                    check("ready_after_done", cmd_ready, 1);
                    check("idle_after_done", busy, 0);
                    check("no_primsel_after_done", primSelect, 0);
                    finished = 1'b1;
                end else begin
                    check("busy", busy, 1);
                    check("ready_low_busy", cmd_ready, 0);
                    check("primSelect", primSelect, pending && !fb_full);
                    if (pending && !fb_full) begin
                        check($sformatf("seg%0d_positions", seg), positions, exp_q[seg]);
                        pending = 1'b0;
                        waiting = 1'b1;
                        cnt     = lat;
                    end else if (waiting) begin
                        check("positions_stable", positions, exp_q[seg]);
                    end
                end
                @(posedge clk);
                if (ld) begin
                    waiting = 1'b0;
                    seg++;
                    if (seg == exp_q.size()) done_due = 1'b1;
                    else pending = 1'b1;
                end
                #1;
                lineDone = 1'b0;
            end
        end
        if (aborted) begin
            rst      = 1'b1;
            lineDone = 1'b0;
            fb_full  = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            check("rst_busy", busy, 0);
            check("rst_primsel", primSelect, 0);
            check("rst_positions", positions, 0);
            check("rst_prim_done", prim_done, 0);
            check("rst_cmd_err", cmd_err, 0);
            check("rst_ready_low", cmd_ready, 0);
            @(posedge clk); #1;
            rst      = 1'b0;
            lineDone = 1'b1;
            @(negedge clk);
            check("post_rst_ready", cmd_ready, 1);
            check("post_rst_busy", busy, 0);
            @(posedge clk); #1;
            lineDone = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("stray_done_ignored", prim_done, 0);
                check("stray_no_primsel", primSelect, 0);
                check("stray_not_busy", busy, 0);
                @(posedge clk); #1;
            end
        end else if (!finished) begin
            check("timeout", 0, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = 2'b00;
        cmd_v0    = '0;
        cmd_v1    = '0;
        cmd_v2    = '0;
        fb_full   = 1'b1;
        lineDone  = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_ready", cmd_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_primsel", primSelect, 0);
        check("reset_positions", positions, 0);
        check("reset_prim_done", prim_done, 0);
        check("reset_cmd_err", cmd_err, 0);
        check("reset_stop", stop, 1);
        @(posedge clk); #1;
        rst     = 1'b0;
        fb_full = 1'b0;
        @(negedge clk);
        check("ready_after_reset", cmd_ready, 1);

        // Directed cases
        run_cmd(2'b00, pt(0, 0), pt(639, 479), pt(0, 0), 5, 0, 1'b0, -1);
        run_cmd(2'b01, pt(10, 20), pt(100, 50), pt(0, 0), 3, 0, 1'b0, -1);
        run_cmd(2'b10, pt(0, 0), pt(200, 0), pt(100, 150), 2, 0, 1'b0, -1);
        run_cmd(2'b00, pt(700, 500), pt(5, 5), pt(0, 0), 1, 0, 1'b0, -1);
        run_cmd(2'b00, pt(3, 4), pt(30, 40), pt(0, 0), 2, 4, 1'b0, -1);
        run_cmd(2'b01, pt(7, 7), pt(7, 7), pt(0, 0), 1, 0, 1'b0, -1);
        run_cmd(2'b11, pt(1, 2), pt(3, 4), pt(5, 6), 1, 0, 1'b0, -1);
        run_cmd(2'b01, pt(10, 20), pt(100, 50), pt(0, 0), 4, 0, 1'b0, 1);

        // Random commands, including out-of-range vertices and frame-buffer stalls
        for (int n = 0; n < 30; n++) begin
            logic [1:0] t;
            t = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            run_cmd(t, 19'($urandom), 19'($urandom), 19'($urandom),
                    int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), 1'b1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prim_scheduler.md
# prim_scheduler

Primitive dispatcher between the command front end and the `bresenline` line generator. It accepts one draw command at a time: a line, a rectangle outline or a triangle outline. It breaks each command into line segments, clamps coordinates to the 640x480 frame, and issues the segments one by one on `positions`/`primSelect`. It waits for `lineDone` after each segment and forwards frame-buffer back-pressure to the generator's `stop`.

## Interface
Parameters:
- `X_MAX`, default 639: largest legal x; x inputs above it are clamped to it.
- `Y_MAX`, default 479: largest legal y; y inputs above it are clamped to it.

Ports:
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: a command is presented.
- `cmd_ready`  out  1: the block can accept a command. High only in IDLE.
- `cmd_type`  in  2: command type. 00 = line, 01 = rectangle, 10 = triangle, 11 = reserved.
- `cmd_v0`, `cmd_v1`, `cmd_v2`  in  19 each: vertices, packed as {x[9:0], y[8:0]}. `cmd_v2` is used only for triangles.
- `fb_full`  in  1: frame-buffer write path is stalled.
- `positions`  out  38: segment to draw, packed as {x0[9:0], y0[8:0], x1[9:0], y1[8:0]}.
- `primSelect`  out  1: one-cycle start pulse to the line generator.
- `lineDone`  in  1: one-cycle pulse from the generator when the current segment's last pixel is emitted.
- `stop`  out  1: pause to the generator. Equals `fb_full` (combinational).
- `busy`  out  1: a command is in progress.
- `prim_done`  out  1: one-cycle pulse when the last segment of a command completes.
- `cmd_err`  out  1: one-cycle pulse when a reserved-type command is accepted.

## Operation
- The vertices are latched and clamped on acceptance (`cmd_valid & cmd_ready`).
  - x = min(x, X_MAX), y = min(y, Y_MAX). Clamping is done per field, unsigned.
  - In what follows, (x0,y0), (x1,y1), (x2,y2) are the clamped `cmd_v0`, `cmd_v1`, `cmd_v2`.
- Segment lists, issued in this order:
  - Line: 1 segment, (x0,y0)->(x1,y1).
  - Rectangle: 4 segments, (x0,y0)->(x1,y0), (x1,y0)->(x1,y1), (x1,y1)->(x0,y1), (x0,y1)->(x0,y0).
  - Triangle: 3 segments, v0->v1, v1->v2, v2->v0.
  - Reserved: no segments. Accepted and dropped; `cmd_err` pulses the next cycle; the block stays in IDLE.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: `cmd_ready`=1. On a valid line/rect/tri command: clear segment index, go to ISSUE.
  - ISSUE: drive `positions` for the current segment.
    - If `fb_full`=0: assert `primSelect` for this one cycle, go to WAIT.
    - If `fb_full`=1: hold in ISSUE with `primSelect`=0.
  - WAIT: `positions` held stable. `lineDone` is sampled only in this state.
    - On `lineDone`, if segments remain: index+1, go to ISSUE.
    - On `lineDone` at the last segment: `prim_done` pulses the next cycle, go to IDLE.
- Degenerate segments (start = end) are still issued. Zero-size rectangles issue 4 identical segments.
- `lineDone` outside WAIT is ignored.
- `stop` passes `fb_full` through in every state, including during reset.

## Timing
- Reset values: state IDLE, segment index 0, `positions`=0, `primSelect`=0, `busy`=0, `prim_done`=0, `cmd_err`=0. `cmd_ready` is 0 while `rst` is high and 1 from the first cycle after.
- A command accepted at edge T gives ISSUE in cycle T+1, with `primSelect` high in that cycle when `fb_full`=0.
- `lineDone` at edge D gives:
  - the next segment's `primSelect` in cycle D+1 (one cycle of ISSUE), or
  - for the last segment, `prim_done`=1 and `cmd_ready`=1 in cycle D+1.
- Back-to-back commands: a new command may be accepted in the cycle `prim_done` is high.
- `busy` is 1 in ISSUE and WAIT, and 0 in IDLE.
- `positions` changes only on entry to ISSUE. It is stable from the `primSelect` cycle through `lineDone`.
- Reset mid-command: the command is discarded, all outputs return to reset values on the next edge, and no `prim_done` is produced.

## Test plan
- Line {v0=(0,0), v1=(639,479)}, generator model returns `lineDone` 5 cycles after `primSelect`:
  - exactly one `primSelect`, with `positions`={10'd0,9'd0,10'd639,9'd479};
  - `prim_done` one cycle after `lineDone`.
- Rectangle v0=(10,20), v1=(100,50):
  - four `primSelect` pulses with `positions` {10,20,100,20}, {100,20,100,50}, {100,50,10,50}, {10,50,10,20};
  - a single `prim_done` after the 4th `lineDone`.
- Triangle v0=(0,0), v1=(200,0), v2=(100,150):
  - segments {0,0,200,0}, {200,0,100,150}, {100,150,0,0}, in that order.
- Clamp: line v0=(700,500), v1=(5,5):
  - `positions`={10'd639,9'd479,10'd5,9'd5}.
- `fb_full`=1 held for 4 cycles after acceptance:
  - `primSelect` stays 0 and `stop`=1 throughout;
  - `primSelect` pulses in the first cycle `fb_full`=0.
- Reserved type 11, then `rst` asserted during WAIT of a rectangle's 2nd segment:
  - the reserved command gives a `cmd_err` pulse and no `primSelect`;
  - after the reset edge, all outputs are 0 and a later `lineDone` produces nothing.
